// File: rtl/tile_color_map_pkg.sv
// ----------------------------------------------------------------------------
// tile_color_map_pkg
// Shared definitions for the tile colour map: 3-bit colour codes, display
// geometry (96 x 64 pixels) and a helper that picks the cursor overlay colour.
// ----------------------------------------------------------------------------
package tile_color_map_pkg;

    typedef logic [2:0] color_t;

    localparam color_t COLOR_RED       = 3'd7;
    localparam color_t COLOR_GREEN     = 3'd6;
    localparam color_t COLOR_YELLOW    = 3'd5;
    localparam color_t COLOR_TURQUOISE = 3'd4;
    localparam color_t COLOR_BLACK     = 3'd3;
    localparam color_t COLOR_BLUE      = 3'd2;
    localparam color_t COLOR_WHITE     = 3'd1;
    localparam color_t COLOR_PURPLE    = 3'd0;

    localparam int DISP_W     = 96;
    localparam int DISP_H     = 64;
    localparam int NUM_PIXELS = DISP_W * DISP_H;

    // The cursor is drawn white, except over white tiles where it turns black
    // so it stays visible.
    function automatic color_t cursor_color(input color_t stored);
        return (stored == COLOR_WHITE) ? COLOR_BLACK : COLOR_WHITE;
    endfunction

endpackage

// File: rtl/tile_color_ram.sv
// ----------------------------------------------------------------------------
// tile_color_ram
// Tile colour storage: DEPTH entries of 3 bits, one synchronous write port and
// one synchronous read port. A read of the address written in the same cycle
// returns the old contents.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write colour code
//   raddr  - read address
//   rdata  - registered read data (1-cycle latency)
// ----------------------------------------------------------------------------
module tile_color_ram
    import tile_color_map_pkg::*;
#(
    parameter int DEPTH = 96,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  color_t        wdata,
    input  logic [AW-1:0] raddr,
    output color_t        rdata
);

    color_t mem [DEPTH];

    // NOTE: the storage array has no reset; the clear sweep initialises it,
    // which keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/tile_color_map.sv
// ----------------------------------------------------------------------------
// tile_color_map
// Maps a row-major pixel address on a 96 x 64 display to the 3-bit colour
// code of the tile containing it. Tiles are written through a valid/ready
// port; a clear request sweeps one colour over every tile, one per cycle.
// Optional build macro: CURSOR_BLINK_EN adds a blinking cursor-tile overlay
// driven by frame_begin.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   pixel_index           - pixel address, x = idx mod 96, y = idx div 96
//   frame_begin           - start-of-frame pulse (blink timing)
//   wr_valid/wr_ready     - tile write handshake
//   wr_col/wr_row/wr_color- tile address and colour for the write
//   clr_req/clr_color     - fill-all request and fill colour
//   cursor_col/cursor_row - cursor tile position
//   busy                  - clear sweep in progress
//   color                 - colour code of the pixel presented one cycle ago
// ----------------------------------------------------------------------------
module tile_color_map
    import tile_color_map_pkg::*;
#(
    parameter int TILE_COLS    = 12,
    parameter int TILE_ROWS    = 8,
    parameter int TILE_PX      = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] pixel_index,
    input  logic        frame_begin,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_col,
    input  logic [2:0]  wr_row,
    input  color_t      wr_color,
    input  logic        clr_req,
    input  color_t      clr_color,
    input  logic [3:0]  cursor_col,
    input  logic [2:0]  cursor_row,
    output logic        busy,
    output color_t      color
);

    localparam int N_TILES = TILE_COLS * TILE_ROWS;
    localparam int AW      = $clog2(N_TILES);

    localparam logic [12:0] W13    = 13'(DISP_W);
    localparam logic [12:0] PX13   = 13'(TILE_PX);
    localparam logic [12:0] COLS13 = 13'(TILE_COLS);
    localparam logic [12:0] NPIX13 = 13'(NUM_PIXELS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] sweep_addr;
    color_t        fill_color;

    // ---------------- pixel -> tile decode ----------------
    logic          pix_oob;
    logic [12:0]   pix_x, pix_y, tile_col, tile_row;
    logic [AW-1:0] rd_addr;

    always_comb begin
        pix_oob  = (pixel_index >= NPIX13);
        pix_x    = pixel_index % W13;
        pix_y    = pixel_index / W13;
        tile_col = pix_x / PX13;
        tile_row = pix_y / PX13;
        // Off-display addresses read tile 0; the output is forced black anyway.
        rd_addr  = pix_oob ? '0 : AW'(tile_row * COLS13 + tile_col);
    end

    // ---------------- write port arbitration ----------------
    logic          wr_col_ok;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    color_t        ram_wdata;

    assign busy      = (state == ST_CLEAR);
    assign wr_ready  = (state == ST_IDLE) && !clr_req;
    assign wr_col_ok = (32'(wr_col) < TILE_COLS);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it holding a value and infer a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = AW'(32'(wr_row) * TILE_COLS + 32'(wr_col));
        ram_wdata = wr_color;
        if (!rst && state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep_addr;
            ram_wdata = fill_color;
        end else if (wr_valid && wr_ready && wr_col_ok) begin
            ram_we = 1'b1;
        end
    end

    // ---------------- clear FSM ----------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_CLEAR;
            sweep_addr <= '0;
            fill_color <= COLOR_BLACK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state      <= ST_CLEAR;
                        sweep_addr <= '0;
                        fill_color <= clr_color;
                    end
                end
                default: begin
                    if (sweep_addr == AW'(N_TILES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- storage ----------------
    color_t rd_data;

    tile_color_ram #(
        .DEPTH (N_TILES),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Off-display flag travels alongside the RAM read; reset value forces the
    // output black until the first real read returns.
    logic oob_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_q <= 1'b1;
        end else begin
            oob_q <= pix_oob;
        end
    end

`ifdef CURSOR_BLINK_EN
    // ---------------- cursor blink overlay ----------------
    logic [15:0] blink_cnt;
    logic        blink_phase;
    logic        cursor_hit_q;
    logic        cursor_hit;

    assign cursor_hit = (32'(cursor_col) < TILE_COLS)
                     && (tile_col == 13'(cursor_col))
                     && (tile_row == 13'(cursor_row));

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            cursor_hit_q <= 1'b0;
        end else begin
            cursor_hit_q <= cursor_hit && !pix_oob;
            if (frame_begin) begin
                if (blink_cnt == 16'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        color = rd_data;
        if (oob_q) begin
            color = COLOR_BLACK;
        end else if (blink_phase && cursor_hit_q) begin
            color = cursor_color(rd_data);
        end
    end
`else
    // Cursor and frame inputs have no function in this build.
    logic unused_cursor_inputs;
    localparam int unused_blink_frames = BLINK_FRAMES;

    assign unused_cursor_inputs = ^{frame_begin, cursor_col, cursor_row};
    assign color = oob_q ? COLOR_BLACK : rd_data;
`endif

endmodule

// File: tb/tb_tile_color_map.sv
// ----------------------------------------------------------------------------
// tb_tile_color_map
// Directed bench for tile_color_map with hand-computed expected colours.
// ----------------------------------------------------------------------------
module tb_tile_color_map;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] pixel_index;
    logic        frame_begin;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_col;
    logic [2:0]  wr_row;
    logic [2:0]  wr_color;
    logic        clr_req;
    logic [2:0]  clr_color;
    logic [3:0]  cursor_col;
    logic [2:0]  cursor_row;
    logic        busy;
    logic [2:0]  color;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tile_color_map #(
        .TILE_COLS    (12),
        .TILE_ROWS    (8),
        .TILE_PX      (8),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_index (pixel_index),
        .frame_begin (frame_begin),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_col      (wr_col),
        .wr_row      (wr_row),
        .wr_color    (wr_color),
        .clr_req     (clr_req),
        .clr_color   (clr_color),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy),
        .color       (color)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_px(input string tag, input int p, input int exp);
        pixel_index = 13'(p);
        tick();
        check(tag, 32'(color), 32'(exp));
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic write_tile(input int c, input int r, input int col);
        wr_col   = 4'(c);
        wr_row   = 3'(r);
        wr_color = 3'(col);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_frames(input int k);
        for (int i = 0; i < k; i++) begin
            frame_begin = 1'b1;
            tick();
            frame_begin = 1'b0;
            tick();
        end
    endtask

    // Pixel near the middle of tile (c, r).
    function automatic int tile_px(input int c, input int r);
        return r * 768 + 5 * 96 + c * 8 + 3;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int k;

        rst         = 1'b1;
        pixel_index = '0;
        frame_begin = 1'b0;
        wr_valid    = 1'b0;
        wr_col      = '0;
        wr_row      = '0;
        wr_color    = '0;
        clr_req     = 1'b0;
        clr_color   = '0;
        cursor_col  = '0;
        cursor_row  = '0;

        // ---- reset and power-up sweep ----
        tick();
        tick();
        check("reset_color", 32'(color), 32'd3);
        check("reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        wait_sweep(n);
        check("reset_busy_cycles", 32'(n), 32'd96);
        check_px("px0_black", 0, 3);
        check_px("px6143_black", 6143, 3);
        check_px("px6144_oob", 6144, 3);
        check_px("px8191_oob", 8191, 3);

        // ---- basic write: col 2, row 1, red ----
        wr_col = 4'd2; wr_row = 3'd1; wr_color = 3'd7; wr_valid = 1'b1;
        #1;
        check("wr_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        check_px("px784", 784, 7);
        check_px("px783", 783, 3);
        check_px("px791_same_tile", 791, 7);
        check_px("px792_next_col", 792, 3);
        check_px("px1456_tile_bottom", 1456, 7);
        check_px("px1552_next_row", 1552, 3);

        // ---- read during write returns the old value ----
        pixel_index = '0;
        write_tile(0, 0, 4);
        check("rbw_old", 32'(color), 32'd3);
        tick();
        check("rbw_new", 32'(color), 32'd4);

        // ---- out-of-range column is dropped ----
        wr_col = 4'd12; wr_row = 3'd0; wr_color = 3'd6; wr_valid = 1'b1;
        #1;
        check("wr_ready_col12", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        check_px("drop_alias_row1", 768, 3);
        check_px("drop_tile0", 0, 4);
        check_px("drop_col11", 88, 3);

        // ---- clear wins over a simultaneous write; write held until ready ----
        clr_color = 3'd5; clr_req = 1'b1;
        wr_col = 4'd5; wr_row = 3'd3; wr_color = 3'd1; wr_valid = 1'b1;
        #1;
        check("wr_ready_clr", 32'(wr_ready), 32'd0);
        tick();
        clr_req = 1'b0;
        check("wr_ready_busy", 32'(wr_ready), 32'd0);
        n = 0;
        while (busy && n < 200) begin
            // A second clear request mid-sweep must be ignored.
            clr_req   = (n == 20);
            clr_color = (n == 20) ? 3'd2 : 3'd5;
            tick();
            n++;
        end
        clr_req = 1'b0;
        check("clr_busy_cycles", 32'(n), 32'd96);
        k = 0;
        while (!wr_ready && k < 10) begin
            tick();
            k++;
        end
        check("held_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 12; c++) begin
                check_px($sformatf("clr_tile_%0d_%0d", c, r), tile_px(c, r),
                         (c == 5 && r == 3) ? 1 : 5);
            end
        end

        // ---- reset in the middle of a clear ----
        clr_color = 3'd2; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        pixel_index = '0;
        for (int i = 0; i < 40; i++) tick();
        check("mid_sweep_tile0", 32'(color), 32'd2);
        rst = 1'b1;
        tick();
        check("mid_rst_color", 32'(color), 32'd3);
        check("mid_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        wait_sweep(n);
        check("mid_rst_busy_cycles", 32'(n), 32'd96);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 12; c++) begin
                check_px($sformatf("rst_tile_%0d_%0d", c, r), tile_px(c, r), 3);
            end
        end

        // ---- cursor overlay ----
        write_tile(0, 0, 6);
        cursor_col = 4'd0; cursor_row = 3'd0;
`ifdef CURSOR_BLINK_EN
        pulse_frames(2);
        check_px("blink_on_px0", 0, 1);
        check_px("blink_on_px679", 679, 1);
        check_px("blink_neighbor", 8, 3);
        cursor_col = 4'd12;
        check_px("blink_cursor_oob", 0, 6);
        cursor_col = 4'd0;
        pulse_frames(2);
        check_px("blink_off_px0", 0, 6);
        write_tile(0, 0, 1);
        pulse_frames(2);
        check_px("blink_on_white", 0, 3);
`else
        pulse_frames(2);
        check_px("no_blink_px0", 0, 6);
        pulse_frames(2);
        check_px("no_blink_px0_again", 0, 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
